// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid: elastic pipeline stage with two-entry skid buffer, flush and saturating bubble counter
module pipe_stage_skid #(
  parameter int DATA_W     = 32,
  parameter int CNT_W      = 16,
  parameter bit CLEAR_DATA = 1'b1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              up_valid_i,
  output logic              up_ready_o,
  input  logic [DATA_W-1:0] up_data_i,
  output logic              dn_valid_o,
  input  logic              dn_ready_i,
  output logic [DATA_W-1:0] dn_data_o,
  output logic [1:0]        occupancy_o,
  input  logic              cnt_clr_i,
  output logic [CNT_W-1:0]  bubble_cnt_o
);
  typedef enum logic [1:0] {EMPTY = 2'd0, HALF = 2'd1, FULL = 2'd2} state_t;
  localparam logic [DATA_W-1:0] ZERO = '0;
  state_t            state_q, state_d;
  logic [DATA_W-1:0] main_q, main_d, skid_q, skid_d;
  logic              up_ready_q, up_ready_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              up_fire, dn_fire;
  always_comb begin
    up_fire = up_valid_i && up_ready_q;
    dn_fire = (state_q != EMPTY) && dn_ready_i;
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      EMPTY: if (up_fire) begin
        state_d = HALF;
        main_d  = up_data_i;
      end
      HALF: if (up_fire && dn_fire) begin
        main_d = up_data_i;
      end else if (up_fire) begin
        state_d = FULL;
        skid_d  = up_data_i;
      end else if (dn_fire) begin
        state_d = EMPTY;
        main_d  = CLEAR_DATA ? ZERO : main_q;
      end
      FULL: if (dn_fire) begin
        state_d = HALF;
        main_d  = skid_q;
        skid_d  = CLEAR_DATA ? ZERO : skid_q;
      end
      default: state_d = EMPTY;
    endcase
    // flush wins over any transfer, including an accepted up-fire
    if (flush_i) begin
      state_d = EMPTY;
      main_d  = CLEAR_DATA ? ZERO : main_d;
      skid_d  = CLEAR_DATA ? ZERO : skid_d;
    end
    up_ready_d = (state_d != FULL);
    cnt_d = cnt_clr_i ? '0 :
            (dn_ready_i && state_q == EMPTY && cnt_q != '1) ? cnt_q + CNT_W'(1) : cnt_q;
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= EMPTY;
      main_q     <= '0;
      skid_q     <= '0;
      up_ready_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      main_q     <= main_d;
      skid_q     <= skid_d;
      up_ready_q <= up_ready_d;
      cnt_q      <= cnt_d;
    end
  end
  assign up_ready_o   = up_ready_q;
  assign dn_valid_o   = (state_q != EMPTY);
  assign dn_data_o    = main_q;
  assign occupancy_o  = state_q;
  assign bubble_cnt_o = cnt_q;
endmodule

// File: tb/tb_pipe_stage_skid.sv
// tb_pipe_stage_skid: directed table, corner sequences and randomized queue-model check of pipe_stage_skid
module tb_pipe_stage_skid;
  localparam logic H = 1'b1;
  localparam logic L = 1'b0;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0, uv = 1'b0, dr = 1'b0, clr = 1'b0;
  logic [63:0] data = '0;
  logic        a_rdy, a_vld, w_rdy, w_vld, n_rdy, n_vld;
  logic [7:0]  a_data;
  logic [63:0] w_data;
  logic        n_data;
  logic [1:0]  a_occ, w_occ, n_occ;
  logic [1:0]  a_cnt;
  logic [15:0] w_cnt, n_cnt;
  int          n_pass = 0, n_tot = 0;

  always #5 clk = ~clk;

  pipe_stage_skid #(.DATA_W(8), .CNT_W(2), .CLEAR_DATA(1'b1)) u_a (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .up_valid_i(uv), .up_ready_o(a_rdy),
    .up_data_i(data[7:0]), .dn_valid_o(a_vld), .dn_ready_i(dr), .dn_data_o(a_data),
    .occupancy_o(a_occ), .cnt_clr_i(clr), .bubble_cnt_o(a_cnt));
  pipe_stage_skid #(.DATA_W(64), .CNT_W(16), .CLEAR_DATA(1'b1)) u_w (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .up_valid_i(uv), .up_ready_o(w_rdy),
    .up_data_i(data), .dn_valid_o(w_vld), .dn_ready_i(dr), .dn_data_o(w_data),
    .occupancy_o(w_occ), .cnt_clr_i(clr), .bubble_cnt_o(w_cnt));
  pipe_stage_skid #(.DATA_W(1), .CNT_W(16), .CLEAR_DATA(1'b0)) u_n (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .up_valid_i(uv), .up_ready_o(n_rdy),
    .up_data_i(data[0]), .dn_valid_o(n_vld), .dn_ready_i(dr), .dn_data_o(n_data),
    .occupancy_o(n_occ), .cnt_clr_i(clr), .bubble_cnt_o(n_cnt));

  typedef struct packed {
    logic       uv;
    logic [7:0] d;
    logic       dr, fl, clr;
    logic       rdy, vld;
    logic [7:0] dd;
    logic [1:0] occ, cnt;
  } vec_t;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [63:0] d, input logic r, input logic f, input logic c);
    uv = v; data = d; dr = r; flush = f; clr = c;
  endtask

  vec_t        vec [18];
  logic [63:0] q [$];
  logic        rdy_m;
  int          cnt_a_m, cnt_w_m;

  initial begin
    vec[0]  = '{H, 8'h01, H, L, L, H, H, 8'h01, 2'd1, 2'd1};
    vec[1]  = '{H, 8'h02, H, L, L, H, H, 8'h02, 2'd1, 2'd1};
    vec[2]  = '{H, 8'h03, H, L, L, H, H, 8'h03, 2'd1, 2'd1};
    vec[3]  = '{L, 8'h00, H, L, L, H, L, 8'h00, 2'd0, 2'd1};
    vec[4]  = '{L, 8'h00, L, L, H, H, L, 8'h00, 2'd0, 2'd0};
    vec[5]  = '{H, 8'h0A, L, L, L, H, H, 8'h0A, 2'd1, 2'd0};
    vec[6]  = '{H, 8'h0B, L, L, L, L, H, 8'h0A, 2'd2, 2'd0};
    vec[7]  = '{H, 8'h0D, L, L, L, L, H, 8'h0A, 2'd2, 2'd0};
    vec[8]  = '{L, 8'h00, H, L, L, H, H, 8'h0B, 2'd1, 2'd0};
    vec[9]  = '{L, 8'h00, H, L, L, H, L, 8'h00, 2'd0, 2'd0};
    vec[10] = '{L, 8'h00, H, L, L, H, L, 8'h00, 2'd0, 2'd1};
    vec[11] = '{H, 8'h05, L, L, L, H, H, 8'h05, 2'd1, 2'd1};
    vec[12] = '{H, 8'h06, L, L, L, L, H, 8'h05, 2'd2, 2'd1};
    vec[13] = '{H, 8'h0C, L, H, L, H, L, 8'h00, 2'd0, 2'd1};
    vec[14] = '{L, 8'h00, H, L, L, H, L, 8'h00, 2'd0, 2'd2};
    vec[15] = '{H, 8'h07, L, L, L, H, H, 8'h07, 2'd1, 2'd2};
    vec[16] = '{H, 8'h08, H, H, L, H, L, 8'h00, 2'd0, 2'd2};
    vec[17] = '{L, 8'h00, H, L, L, H, L, 8'h00, 2'd0, 2'd3};

    // reset values and release
    #12;
    chk("rst_rdy", 64'(a_rdy), 64'd0);
    chk("rst_vld", 64'(a_vld), 64'd0);
    chk("rst_occ", 64'(a_occ), 64'd0);
    chk("rst_cnt", 64'(a_cnt), 64'd0);
    rst = 1'b0;
    tick();
    chk("rel_rdy", 64'(a_rdy), 64'd1);
    chk("rel_occ", 64'(a_occ), 64'd0);

    for (int i = 0; i < 18; i++) begin
      drive(vec[i].uv, 64'(vec[i].d), vec[i].dr, vec[i].fl, vec[i].clr);
      tick();
      chk($sformatf("vec%0d_rdy", i), 64'(a_rdy), 64'(vec[i].rdy));
      chk($sformatf("vec%0d_vld", i), 64'(a_vld), 64'(vec[i].vld));
      chk($sformatf("vec%0d_data", i), 64'(a_data), 64'(vec[i].dd));
      chk($sformatf("vec%0d_occ", i), 64'(a_occ), 64'(vec[i].occ));
      chk($sformatf("vec%0d_cnt", i), 64'(a_cnt), 64'(vec[i].cnt));
    end

    // counter saturation at CNT_W=2, then clear beats a bubble
    drive(L, 64'd0, L, L, H);
    tick();
    chk("sat_clr0", 64'(a_cnt), 64'd0);
    for (int i = 0; i < 5; i++) begin
      drive(L, 64'd0, H, L, L);
      tick();
      chk($sformatf("sat_%0d", i), 64'(a_cnt), 64'(i < 3 ? i + 1 : 3));
    end
    drive(L, 64'd0, H, L, H);
    tick();
    chk("sat_clr_bubble", 64'(a_cnt), 64'd0);

    // asynchronous reset with two entries held
    drive(H, 64'h11, L, L, L);
    tick();
    data = 64'h22;
    tick();
    chk("pre_rst_occ", 64'(a_occ), 64'd2);
    #2 rst = 1'b1;
    #1;
    chk("arst_rdy", 64'(a_rdy), 64'd0);
    chk("arst_vld", 64'(a_vld), 64'd0);
    chk("arst_occ", 64'(a_occ), 64'd0);
    chk("arst_data", 64'(a_data), 64'd0);
    chk("arst_wdata", w_data, 64'd0);
    chk("arst_ndata", 64'(n_data), 64'd0);
    chk("arst_wocc", 64'(w_occ), 64'd0);
    tick();
    #2 rst = 1'b0;
    #1;
    chk("rel2_rdy_before", 64'(a_rdy), 64'd0);
    tick();
    chk("rel2_rdy", 64'(a_rdy), 64'd1);
    chk("rel2_occ", 64'(a_occ), 64'd0);

    // randomized run against a FIFO model
    rdy_m = 1'b1;
    cnt_a_m = 0;
    cnt_w_m = 0;
    for (int i = 0; i < 3000; i++) begin
      logic v, r, f, c, vld_m, upf, dnf;
      v = ($urandom_range(0, 9) < 7);
      r = ($urandom_range(0, 9) < 6);
      f = ($urandom_range(0, 15) == 0);
      c = ($urandom_range(0, 31) == 0);
      drive(v, {$urandom, $urandom}, r, f, c);
      vld_m = (q.size() > 0);
      upf = v && rdy_m;
      dnf = vld_m && r;
      if (c) begin
        cnt_a_m = 0;
        cnt_w_m = 0;
      end else if (r && !vld_m) begin
        if (cnt_a_m < 3) cnt_a_m++;
        if (cnt_w_m < 65535) cnt_w_m++;
      end
      if (dnf) void'(q.pop_front());
      if (upf) q.push_back(data);
      if (f) q.delete();
      rdy_m = (q.size() < 2);
      tick();
      chk("rnd_w_occ", 64'(w_occ), 64'(q.size()));
      chk("rnd_n_occ", 64'(n_occ), 64'(q.size()));
      chk("rnd_a_occ", 64'(a_occ), 64'(q.size()));
      chk("rnd_w_vld", 64'(w_vld), 64'(q.size() > 0));
      chk("rnd_w_rdy", 64'(w_rdy), 64'(rdy_m));
      chk("rnd_n_rdy", 64'(n_rdy), 64'(rdy_m));
      chk("rnd_w_cnt", 64'(w_cnt), 64'(cnt_w_m));
      chk("rnd_a_cnt", 64'(a_cnt), 64'(cnt_a_m));
      if (q.size() > 0) begin
        chk("rnd_w_data", w_data, q[0]);
        chk("rnd_n_data", 64'(n_data), 64'(q[0][0]));
        chk("rnd_a_data", 64'(a_data), 64'(q[0][7:0]));
      end else begin
        chk("rnd_a_clear", 64'(a_data), 64'd0);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
